mem_block_ctrl: RTL and testbench
=================================

Name: mem_block_ctrl

Overview:
- Main-memory side of the cache refill/writeback path; sits directly downstream of the direct-mapped cache controller.
- Serves whole-block transfers: a block read streams 16 words to the cache; a block write collects 16 words and commits them atomically.
- Stand-in for a slow DRAM, with programmable access latency and a valid/ready request handshake.

Parameters:
- MEM_BLOCKS, 1024, number of blocks in the backing array (power of two).
- WORDS_PER_BLOCK, 16, words per block (power of two, ≥2).
- WORD_W, 32, bits per word.
- BADDR_W, 22, block-address width ({tag,index} from the cache: 32 - 4 - 6 bits).
- LATENCY, 4, wait cycles between request acceptance and data or commit completion (0..255).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_write  in  1  0 = block read (refill), 1 = block write (writeback).
- req_baddr  in  BADDR_W  block address.
- wdata_valid  in  1  write word present.
- wdata_ready  out  1  controller accepting write words.
- wdata  in  WORD_W  write word; words arrive in order 0..WORDS_PER_BLOCK-1.
- rdata_valid  out  1  read word valid this cycle.
- rdata  out  WORD_W  read word.
- rdata_last  out  1  marks the final word of a read burst.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  qualified by done; address out of range.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n`, asynchronous, active-low.
- Reset values:
  - State machine goes to IDLE.
  - req_ready=0 while rst_n=0, then 1 in IDLE.
  - wdata_ready, rdata_valid, rdata_last, done, err all 0; rdata = 0.
  - Word counter and latency counter are cleared.
  - The memory array and write buffer are NOT reset; the array is zero-initialised at time 0 only.
- States:
  - IDLE:
    - req_ready=1.
    - Handshake at edge N (req_valid & req_ready): latch req_write and req_baddr.
    - Set oor = (req_baddr ≥ MEM_BLOCKS).
    - Go to WR_COLLECT if a write; else go to WAIT, or RD_BURST if LATENCY=0.
  - WAIT:
    - Counts LATENCY cycles.
    - Exits to RD_BURST for a read, or DONE for a write.
  - RD_BURST:
    - Drives rdata_valid=1 for exactly WORDS_PER_BLOCK consecutive cycles, with no backpressure.
    - rdata = mem[baddr][k] for k = 0..WORDS_PER_BLOCK-1, or 0 when oor.
    - rdata_last=1 with word WORDS_PER_BLOCK-1, then go to DONE.
    - For a read accepted at edge N: first word in cycle N+1+LATENCY, done in cycle N+1+LATENCY+WORDS_PER_BLOCK.
  - WR_COLLECT:
    - wdata_ready=1; each wdata_valid&wdata_ready beat stores into buf[k] and increments k.
    - Gaps in wdata_valid are allowed.
    - After the last beat go to COMMIT.
  - COMMIT:
    - Single cycle: copies buf to mem[baddr] unless oor (data discarded).
    - Then go to WAIT, or DONE if LATENCY=0.
  - DONE:
    - done=1 for one cycle; err=oor; then return to IDLE.
    - req_ready stays 0 in DONE, so there is at least one idle gap between transactions.
- Handshake and boundary rules:
  - Requests are never accepted outside IDLE; req_valid may stay high and is taken in the next IDLE cycle.
  - wdata beats outside WR_COLLECT are ignored.
  - Address decode: array index = req_baddr[$clog2(MEM_BLOCKS)-1:0], used only when not oor.
  - Reset asserted mid-transaction:
    - The transaction is abandoned and no done is produced.
    - A partial write never reaches the array, because the commit is atomic.
    - A write already in COMMIT at the reset edge is also lost.
  - Read-after-write to the same block returns the new data, since the commit precedes the write's done.

Optional Feature:
- Macro: MEM_CTRL_STATS_EN.
- When defined, adds output ports:
  - rd_count[15:0]: completed reads.
  - wr_count[15:0]: completed writes.
  - err_count[15:0]: transactions with err.
- Counter behaviour:
  - Each increments on the done cycle.
  - Each saturates at 16'hFFFF.
  - Each resets to 0 on rst_n.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Read after write, LATENCY=4:
  - Stimulus: write block 0x00013 with words 0xA000_0000+k back-to-back, then read 0x00013.
  - Response: the write's done comes 1+4 cycles after the 16th beat.
  - Response: the read's rdata_valid starts 5 cycles after acceptance and returns 0xA000_0000..0xA000_000F, rdata_last on word 15, done one cycle later, err=0.
- Gapped write:
  - Stimulus: wdata_valid toggled every other cycle.
  - Response: all 16 words are stored correctly, and done is not asserted until 16 beats are accepted.
- Out of range:
  - Stimulus: read from baddr 0x00400 (MEM_BLOCKS=1024).
  - Response: 16 zero words, done with err=1.
  - Stimulus: write to the same address.
  - Response: err=1, and block 0x000 is unchanged on read-back.
- Reset mid-write:
  - Stimulus: assert rst_n=0 after 7 beats to block 5 (which previously held 0x5555_55xx).
  - Response: all outputs are 0 immediately (asynchronously), no done, and read-back returns the old 0x5555_55xx data.
- Back-to-back requests:
  - Stimulus: req_valid held high with read 0x1, then read 0x2.
  - Response: the second request is accepted only after the first done plus one cycle, and req_ready=0 throughout the first transaction.
- Statistics (MEM_CTRL_STATS_EN defined):
  - Stimulus: 3 reads, 2 writes, 1 oor read.
  - Response: rd_count=4, wr_count=2, err_count=1.

Source files
------------

// File: rtl/mem_block_ctrl.sv
// Block-transfer memory controller behind the cache: 16-word refill bursts and
// atomic 16-word writebacks with a programmable latency. Optional MEM_CTRL_STATS_EN adds counters.
module mem_block_ctrl #(
  parameter int MEM_BLOCKS      = 1024,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int WORD_W          = 32,
  parameter int BADDR_W         = 22,
  parameter int LATENCY         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BADDR_W-1:0] req_baddr,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  input  logic [WORD_W-1:0]  wdata,
  output logic               rdata_valid,
  output logic [WORD_W-1:0]  rdata,
  output logic               rdata_last,
  output logic               done,
  output logic               err,
`ifdef MEM_CTRL_STATS_EN
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic [15:0]        err_count,
`endif
  output logic [2:0]         dbg_state
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int K_W   = $clog2(WORDS_PER_BLOCK);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and rdata has no backpressure.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT       = 3'd1,
    S_RD_BURST   = 3'd2,
    S_WR_COLLECT = 3'd3,
    S_COMMIT     = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic             is_write;
  logic             oor;
  logic [IDX_W-1:0] idx;
  logic [K_W-1:0]   k;
  logic [7:0]       lat_cnt;
  logic             req_fire, wr_fire, lat_end, k_last;

  logic [WORD_W-1:0] mem [MEM_BLOCKS*WORDS_PER_BLOCK] = '{default: '0};
  logic [WORD_W-1:0] wbuf [WORDS_PER_BLOCK];

  assign req_ready   = rst_n && (state == S_IDLE);
  assign req_fire    = req_valid && req_ready;
  assign wdata_ready = (state == S_WR_COLLECT);
  assign wr_fire     = wdata_valid && wdata_ready;
  assign lat_end     = (lat_cnt == 8'(LATENCY - 1));
  assign k_last      = (k == K_W'(WORDS_PER_BLOCK - 1));
  assign rdata_valid = (state == S_RD_BURST);
  assign rdata_last  = rdata_valid && k_last;
  assign rdata       = (rdata_valid && !oor) ? mem[{idx, k}] : '0;
  assign done        = (state == S_DONE);
  assign err         = done && oor;
  assign dbg_state   = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:       if (req_fire) state_nx = req_write ? S_WR_COLLECT :
                                             ((LATENCY == 0) ? S_RD_BURST : S_WAIT);
      S_WAIT:       if (lat_end) state_nx = is_write ? S_DONE : S_RD_BURST;
      S_RD_BURST:   if (k_last) state_nx = S_DONE;
      S_WR_COLLECT: if (wr_fire && k_last) state_nx = S_COMMIT;
      S_COMMIT:     state_nx = (LATENCY == 0) ? S_DONE : S_WAIT;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      oor      <= 1'b0;
      idx      <= '0;
      k        <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (req_fire) begin
        is_write <= req_write;
        oor      <= ({1'b0, req_baddr} >= (BADDR_W+1)'(MEM_BLOCKS));
        idx      <= req_baddr[IDX_W-1:0];
      end
      if (state == S_WAIT) lat_cnt <= lat_cnt + 8'd1;
      else                 lat_cnt <= '0;
      // k wraps back to zero after the last word of a burst or collection
      if ((state == S_RD_BURST) || wr_fire) k <= k + K_W'(1);
      else if (state == S_IDLE)             k <= '0;
    end
  end

  // Reset forces state to IDLE asynchronously, so an interrupted COMMIT never lands.
  always_ff @(posedge clk) begin
    if (wr_fire) wbuf[k] <= wdata;
    if ((state == S_COMMIT) && !oor) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) mem[{idx, K_W'(i)}] <= wbuf[i];
    end
  end

`ifdef MEM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (state == S_DONE) begin
      if (is_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
      if (oor && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl: a transaction table plus hand-written
// sequences for reset-mid-write and back-to-back requests.
module tb_mem_block_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [21:0] req_baddr = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;
`ifdef MEM_CTRL_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
`endif

  mem_block_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_baddr(req_baddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .err(err),
`ifdef MEM_CTRL_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];
  int exp_rd = 0, exp_wr = 0, exp_err_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endfunction

  typedef struct {
    bit          wr;
    logic [21:0] ba;
    logic [31:0] base;
    bit          gap;
    bit          exp_err;
  } vec_t;

  vec_t vecs [11];

  // driver tasks: all sampling and driving happens on the falling edge
  task automatic issue_req(input bit wr, input logic [21:0] ba);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_baddr = ba;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req accepted within bound", 32'(w < 100), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [21:0] ba, input logic [31:0] base, input bit gap,
                          input bit exp_err, input string tag);
    int beats, cyc, lat;
    bit rdy, early_done;
    beats = 0; cyc = 0; early_done = 1'b0;
    issue_req(1'b1, ba);
    while (beats < 16 && cyc < 200) begin
      if (done) early_done = 1'b1;
      wdata_valid = gap ? cyc[0] : 1'b1;
      wdata = base + 32'(beats);
      rdy = wdata_ready;
      @(negedge clk);
      if (wdata_valid && rdy) beats++;
      cyc++;
    end
    wdata_valid = 1'b0;
    chk({tag, " beats"}, 32'(beats), 32'd16);
    chk({tag, " no done while collecting"}, 32'(early_done), 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    // done follows the 16th beat by one COMMIT cycle plus LATENCY wait cycles
    chk({tag, " done latency"}, 32'(lat), 32'(LAT + 1));
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    if (!exp_err)
      for (int i = 0; i < 16; i++) model_mem[int'(ba) * 16 + i] = base + 32'(i);
    @(negedge clk);
    exp_wr++;
    if (exp_err) exp_err_cnt++;
  endtask

  task automatic do_read(input logic [21:0] ba, input bit exp_err, input string tag);
    int lat, n, key;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      key = int'(ba) * 16 + i;
      e = (exp_err || !model_mem.exists(key)) ? 32'h0 : model_mem[key];
      exp_q.push_back(e);
    end
    issue_req(1'b0, ba);
    lat = 0;
    while (!rdata_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    // falling edges from acceptance to first word: the word appears LATENCY edges later
    chk({tag, " first word latency"}, 32'(lat), 32'(LAT));
    n = 0;
    while (rdata_valid && n < 20) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk($sformatf("%s rdata[%0d]", tag, n), rdata, e);
      chk($sformatf("%s rdata_last[%0d]", tag, n), 32'(rdata_last), 32'(n == 15));
      @(negedge clk);
      n++;
    end
    chk({tag, " burst length"}, 32'(n), 32'd16);
    chk({tag, " done after burst"}, 32'(done), 32'd1);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    exp_q.delete();
    @(negedge clk);
    exp_rd++;
    if (exp_err) exp_err_cnt++;
  endtask

  initial begin
    int beats, cyc, t, acc1, acc2, td, nvalid, lat;
    bit rdy, ready_bad, seen_done;

    vecs[0]  = '{1'b1, 22'h00013,  32'hA000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 22'h00013,  32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b1, 22'h00007,  32'h7700_0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 22'h00007,  32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b1, 22'h00005,  32'h5555_5500, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 22'h00400,  32'h0,         1'b0, 1'b1};
    vecs[6]  = '{1'b1, 22'h00400,  32'hDEAD_BE00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 22'h00000,  32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b1, 22'h003FF,  32'h3FF0_0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 22'h003FF,  32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 22'h3FFFFF, 32'h0,         1'b0, 1'b1};

    // reset values
    #12;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset wdata_ready", 32'(wdata_ready), 32'd0);
    chk("reset rdata_valid", 32'(rdata_valid), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset done/err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) do_write(vecs[i].ba, vecs[i].base, vecs[i].gap, vecs[i].exp_err, $sformatf("vec%0d wr", i));
      else            do_read(vecs[i].ba, vecs[i].exp_err, $sformatf("vec%0d rd", i));
    end

    // reset after 7 beats of a write to block 5
    issue_req(1'b1, 22'h5);
    beats = 0; cyc = 0;
    while (beats < 7 && cyc < 50) begin
      wdata_valid = 1'b1;
      wdata = 32'h1111_0000 + 32'(beats);
      rdy = wdata_ready;
      @(negedge clk);
      if (rdy) beats++;
      cyc++;
    end
    wdata_valid = 1'b0;
    chk("mid-write wdata_ready", 32'(wdata_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset req_ready", 32'(req_ready), 32'd0);
    chk("async reset wdata_ready", 32'(wdata_ready), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("no done after abandoned write", 32'(seen_done), 32'd0);
    do_read(22'h5, 1'b0, "after reset rd");

    // back-to-back reads with req_valid held high
    req_valid = 1'b1; req_write = 1'b0; req_baddr = 22'h1;
    t = 0; acc1 = -1; acc2 = -1; td = -1; nvalid = 0; ready_bad = 1'b0;
    while (acc2 < 0 && t < 200) begin
      if (acc1 >= 0 && td < 0 && req_ready) ready_bad = 1'b1;
      if (rdata_valid && td < 0) nvalid++;
      if (done && td < 0) td = t;
      if (req_ready) begin
        if (acc1 < 0) acc1 = t;
        else          acc2 = t;
      end
      @(negedge clk);
      t++;
      if (acc1 >= 0) req_baddr = 22'h2;
    end
    req_valid = 1'b0;
    chk("b2b req_ready low during first", 32'(ready_bad), 32'd0);
    chk("b2b first burst words", 32'(nvalid), 32'd16);
    chk("b2b first done timing", 32'(td - acc1), 32'(LAT + 17));
    chk("b2b second accept timing", 32'(acc2 - td), 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second err", 32'(err), 32'd0);
    @(negedge clk);
    exp_rd += 2;

`ifdef MEM_CTRL_STATS_EN
    chk("rd_count", 32'(rd_count), 32'(exp_rd));
    chk("wr_count", 32'(wr_count), 32'(exp_wr));
    chk("err_count", 32'(err_count), 32'(exp_err_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
